ahbl_excl_monitor: RTL and testbench
====================================

Name: ahbl_excl_monitor

Overview:
- Global exclusive-access monitor placed in-line between one crossbar slave-side (dst) port and its AHB-Lite slave, typically the main RAM.
- Keeps one reservation per master, indexed by hmaster, at granule resolution.
- Forwards exclusive writes only when the issuing master's reservation is still valid. Failed exclusive writes are turned into IDLE toward the slave and answered locally.
- Drives hexokay back toward the crossbar, so SC/AMO-style sequences from multiple harts are arbitrated correctly.

Parameters:
- N_MASTERS, 2, number of reservation entries; hmaster values >= N_MASTERS never hold a reservation.
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- W_GRANULE, 3, log2 of reservation granule in bytes; granule = haddr[W_ADDR-1:W_GRANULE].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_hready  in  1  bus HREADY from arbiter
- src_hready_resp  out  1  HREADYOUT toward arbiter
- src_hresp  out  1  response toward arbiter
- src_haddr  in  W_ADDR  address
- src_hwrite  in  1  write flag
- src_htrans  in  2  transfer type
- src_hsize / src_hburst / src_hprot / src_hmastlock  in  3/3/4/1  passed to dst unchanged
- src_hwdata  in  W_DATA  write data
- src_hrdata  out  W_DATA  read data
- src_hexcl  in  1  exclusive transfer flag (address phase)
- src_hmaster  in  8  master ID (address phase)
- src_hexokay  out  1  exclusive success (data phase)
- dst_hready  out  1  equals src_hready
- dst_hready_resp  in  1  slave HREADYOUT
- dst_hresp  in  1  slave response
- dst_haddr / dst_hwrite / dst_hsize / dst_hburst / dst_hprot / dst_hmastlock / dst_hwdata  out  as src  pass-through
- dst_htrans  out  2  src_htrans, or IDLE when suppressed
- dst_hrdata  in  W_DATA  slave read data
- dst_hexcl  out  1  src_hexcl pass-through
- dst_hmaster  out  8  src_hmaster pass-through

Behaviour:
- Single clock domain clk. Reset rst is synchronous and active-high.
- Reset state:
  - All res_valid = 0.
  - Data-phase registers dp_valid, dp_excl, dp_write, dp_ok, dp_supp = 0.
  - Therefore src_hexokay = 0, and src_hready_resp/src_hresp/src_hrdata follow dst_*.
- Address-phase accept: acc = src_hready & src_htrans[1]. m = src_hmaster; mv = (m < N_MASTERS); g = granule of src_haddr.
- Reservation match: hit = mv & res_valid[m] & (res_addr[m] == g).
- Suppression (combinational): supp = src_htrans[1] & src_hexcl & src_hwrite & ~hit.
  - When supp = 1, dst_htrans = 2'b00; otherwise dst_htrans = src_htrans.
- Reservation updates, committed on clk edge when acc = 1, in this priority:
  - Exclusive read, mv: res_valid[m] <= 1; res_addr[m] <= g. Any prior entry for m is overwritten.
  - Exclusive read, ~mv: no change.
  - Exclusive write with hit: clear every entry k with res_addr[k] == g, including m.
  - Exclusive write without hit: clear res_valid[m] if mv.
  - Normal write: clear every entry with res_addr[k] == g.
  - Normal read / IDLE / BUSY: no change.
  - Updates are never rolled back on a later ERROR response.
- Data-phase capture when src_hready = 1:
  - dp_valid <= acc
  - dp_excl <= src_hexcl
  - dp_write <= src_hwrite
  - dp_supp <= supp & acc
  - dp_ok <= exclusive read: mv; exclusive write: hit
  - When src_hready = 0, all dp registers hold.
- Response muxing:
  - When dp_supp = 1: src_hready_resp = 1, src_hresp = 0, src_hrdata = 0, src_hexokay = 0. This is a single-cycle OKAY, and the slave sees an IDLE data phase.
  - Otherwise: src_hready_resp = dst_hready_resp, src_hresp = dst_hresp, src_hrdata = dst_hrdata.
  - src_hexokay = dp_valid & dp_excl & dp_ok & ~dp_supp & ~dst_hresp. It is valid while src_hready_resp is high, and 0 in every non-exclusive data phase.
- Back-to-back transfers: the update for transfer N+1 happens at its own accept. It sees state already updated by transfer N's address phase, with no bubble inserted.
- Reset mid-transfer: all reservations and dp state are dropped. The first transfer after reset sees no reservations.
- Latency: zero added cycles on forwarded transfers. Suppressed exclusive writes complete in exactly 1 data-phase cycle.

Test Plan:
- Master 0 exclusive read 0x1000, then exclusive write 0x1004 (same 8B granule) -> write forwarded; hexokay = 1 on both data phases; res_valid[0] = 0 afterward.
- Master 0 exclusive read 0x1000, master 1 normal write 0x1000, master 0 exclusive write 0x1000 -> dst_htrans = 0 on that write; src_hready_resp = 1 in 1 cycle; hexokay = 0; slave memory unchanged.
- Masters 0 and 1 both exclusive read 0x2000; master 1 exclusive write succeeds (hexokay = 1) -> master 0's subsequent exclusive write suppressed, hexokay = 0.
- Exclusive read from hmaster = 5 (N_MASTERS = 2) -> read forwarded with data, hexokay = 0; following exclusive write from 5 suppressed.
- Exclusive write with slave inserting 3 wait states then ERROR -> src_hready_resp low for 3 cycles, hresp = 1, hexokay = 0, reservation still cleared.
- Exclusive read by master 0, assert rst for 1 cycle mid data phase, then exclusive write -> suppressed, hexokay = 0.

Source files
------------

// File: rtl/ahbl_excl_monitor.sv
// In-line AHB-Lite exclusive monitor: one granule reservation per hmaster, failed exclusive writes become IDLE
// toward the slave and complete locally in one OKAY cycle; forwarded transfers add zero latency and follow slave HREADYOUT.
module ahbl_excl_monitor #(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int W_GRANULE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata,
    output logic              dst_hexcl,
    output logic [7:0]        dst_hmaster
);
    localparam int W_G = W_ADDR - W_GRANULE;

    logic [N_MASTERS-1:0] res_valid_q, res_valid_d;
    logic [W_G-1:0]       res_addr_q [N_MASTERS];
    logic [W_G-1:0]       res_addr_d [N_MASTERS];
    logic                 dp_valid_q, dp_excl_q, dp_ok_q, dp_supp_q;

    logic                 acc, mv, hit, supp;
    logic [W_G-1:0]       gran;
    logic [N_MASTERS-1:0] sel;
    logic [N_MASTERS-1:0] same_g;

    assign acc  = src_hready & src_htrans[1];
    assign gran = src_haddr[W_ADDR-1:W_GRANULE];

    // sel is one-hot on the issuing master; all-zero for IDs without an entry
    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            sel[k]    = (src_hmaster == 8'(k));
            same_g[k] = (res_addr_q[k] == gran);
        end
    end

    assign mv   = |sel;
    assign hit  = |(sel & res_valid_q & same_g);
    assign supp = src_htrans[1] & src_hexcl & src_hwrite & ~hit;

    always_comb begin
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        if (acc) begin
            if (src_hexcl && !src_hwrite) begin
                for (int k = 0; k < N_MASTERS; k++) begin
                    if (sel[k]) begin
                        res_valid_d[k] = 1'b1;
                        res_addr_d[k]  = gran;
                    end
                end
            end else if (src_hexcl && hit) begin
                res_valid_d = res_valid_q & ~same_g;
            end else if (src_hexcl && src_hwrite) begin
                res_valid_d = res_valid_q & ~sel;
            end else if (src_hwrite) begin
                res_valid_d = res_valid_q & ~same_g;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= '0;
            dp_valid_q  <= 1'b0;
            dp_excl_q   <= 1'b0;
            dp_ok_q     <= 1'b0;
            dp_supp_q   <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            if (src_hready) begin
                dp_valid_q <= acc;
                dp_excl_q  <= src_hexcl;
                dp_supp_q  <= supp & acc;
                dp_ok_q    <= src_hexcl & (src_hwrite ? hit : mv);
            end
        end
    end

    // Addresses are qualified by res_valid_q, so they carry no reset
    always_ff @(posedge clk) begin
        res_addr_q <= res_addr_d;
    end

    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = supp ? 2'b00 : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;
    assign dst_hexcl     = src_hexcl;
    assign dst_hmaster   = src_hmaster;

    assign src_hready_resp = dp_supp_q ? 1'b1 : dst_hready_resp;
    assign src_hresp       = dp_supp_q ? 1'b0 : dst_hresp;
    assign src_hrdata      = dp_supp_q ? '0 : dst_hrdata;
    assign src_hexokay     = dp_valid_q & dp_excl_q & dp_ok_q & ~dp_supp_q & ~dst_hresp;
endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Scoreboard bench: pipelined AHB-Lite master, wait/error memory slave, and a reference model of
// reservations (master -> granule map) and memory; a monitor checks every completed data phase.
`timescale 1ns/1ps
module tb_ahbl_excl_monitor;
    localparam int NM = 2;

    logic        clk;
    logic        rst;
    logic        src_hready, src_hready_resp, src_hresp;
    logic [31:0] src_haddr;
    logic        src_hwrite;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize, src_hburst;
    logic [3:0]  src_hprot;
    logic        src_hmastlock;
    logic [31:0] src_hwdata, src_hrdata;
    logic        src_hexcl;
    logic [7:0]  src_hmaster;
    logic        src_hexokay;
    logic        dst_hready, dst_hready_resp, dst_hresp;
    logic [31:0] dst_haddr;
    logic        dst_hwrite;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize, dst_hburst;
    logic [3:0]  dst_hprot;
    logic        dst_hmastlock;
    logic [31:0] dst_hwdata, dst_hrdata;
    logic        dst_hexcl;
    logic [7:0]  dst_hmaster;

    ahbl_excl_monitor #(.N_MASTERS(NM), .W_ADDR(32), .W_DATA(32), .W_GRANULE(3)) dut (
        .clk(clk), .rst(rst),
        .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
        .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata),
        .dst_hexcl(dst_hexcl), .dst_hmaster(dst_hmaster)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-slave system: the bus HREADY is this port's own HREADYOUT
    assign src_hready = src_hready_resp;

    typedef struct {
        int          cycles;
        logic        hresp;
        logic        okay;
        logic        chk_rdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        int          waits;
        logic        err;
    } sl_t;

    exp_t        exp_q[$];
    sl_t         sl_q[$];
    int unsigned res_m[int];
    logic [31:0] mdl_mem[int];
    logic [31:0] sl_mem[int];
    logic [31:0] pend_wdata;
    logic        cur_supp;
    int          vectors;
    int          miscompares;

    initial begin
        vectors     = 0;
        miscompares = 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        int i;
        i = int'(a >> 2);
        return mdl_mem.exists(i) ? mdl_mem[i] : mem_init(a);
    endfunction

    function automatic logic [31:0] sl_rd(input logic [31:0] a);
        int i;
        i = int'(a >> 2);
        return sl_mem.exists(i) ? sl_mem[i] : mem_init(a);
    endfunction

    function automatic void clear_gran(input int unsigned g);
        int kill[$];
        foreach (res_m[k]) if (res_m[k] == g) kill.push_back(k);
        foreach (kill[i]) res_m.delete(kill[i]);
    endfunction

    // Waits for the edge that accepts the currently driven address phase, then moves its write data on.
    task automatic wait_accept();
        logic r;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            r = src_hready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 64);
        chk("accept_timeout", 64'(r), 64'd1);
        src_hwdata = pend_wdata;
    endtask

    task automatic xfer(input int m, input logic [31:0] addr, input logic wr, input logic excl,
                        input int waits, input logic err);
        exp_t        e;
        sl_t         s;
        int unsigned g;
        logic        mv, hit, supp;
        logic [31:0] wd;
        wd = $urandom;
        if (err && waits == 0) waits = 1;
        wait_accept();
        g    = addr >> 3;
        mv   = (m < NM);
        hit  = mv && res_m.exists(m) && (res_m[m] == g);
        supp = excl && wr && !hit;
        if (excl && !wr) begin
            if (mv) res_m[m] = g;
        end else if (excl && wr) begin
            if (hit) clear_gran(g);
            else if (mv) res_m.delete(m);
        end else if (wr) begin
            clear_gran(g);
        end
        if (supp) begin
            e.cycles = 1; e.hresp = 1'b0; e.okay = 1'b0; e.chk_rdata = 1'b1; e.rdata = 32'h0;
        end else begin
            e.cycles    = waits + 1;
            e.hresp     = err;
            e.okay      = excl && (wr ? hit : mv) && !err;
            e.chk_rdata = !wr && !err;
            e.rdata     = mdl_rd(addr);
            if (wr && !err) mdl_mem[int'(addr >> 2)] = wd;
            s.addr = addr; s.wr = wr; s.waits = waits; s.err = err;
            sl_q.push_back(s);
        end
        exp_q.push_back(e);
        src_haddr   = addr;
        src_hwrite  = wr;
        src_htrans  = 2'b10;
        src_hexcl   = excl;
        src_hmaster = 8'(m);
        src_hsize   = 3'd2;
        src_hburst  = 3'd0;
        src_hprot   = 4'h3;
        cur_supp    = supp;
        pend_wdata  = wd;
    endtask

    task automatic idle();
        wait_accept();
        src_htrans = 2'b00;
        src_hexcl  = 1'b0;
        src_hwrite = 1'b0;
        cur_supp   = 1'b0;
        pend_wdata = 32'h0;
    endtask

    // One reset cycle overlapping the data phase of the previous (zero-wait) transfer
    task automatic reset_pulse();
        wait_accept();
        src_htrans = 2'b00;
        src_hexcl  = 1'b0;
        src_hwrite = 1'b0;
        cur_supp   = 1'b0;
        pend_wdata = 32'h0;
        rst        = 1'b1;
        res_m.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : slave
        bit          act, s_acc, s_done;
        int          left;
        sl_t         cur;
        logic [31:0] s_addr, s_wdata;
        act = 0; left = 0;
        dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            s_acc   = dst_hready && dst_htrans[1];
            s_done  = dst_hready_resp;
            s_addr  = dst_haddr;
            s_wdata = dst_hwdata;
            @(posedge clk);
            #1;
            if (act) begin
                if (s_done) begin
                    if (cur.wr && !cur.err) sl_mem[int'(cur.addr >> 2)] = s_wdata;
                    act = 0;
                end else begin
                    left--;
                end
            end
            if (s_acc) begin
                if (sl_q.size() == 0) begin
                    chk("slave_unexpected_fwd", 64'(sl_q.size()), 64'd1);
                end else begin
                    cur = sl_q.pop_front();
                    chk("slave_addr", 64'(s_addr), 64'(cur.addr));
                    act  = 1;
                    left = cur.waits + 1;
                end
            end
            if (act) begin
                dst_hready_resp = (left <= 1);
                dst_hresp       = cur.err && (left <= 2);
                dst_hrdata      = cur.wr ? 32'h0 : sl_rd(cur.addr);
            end else begin
                dst_hready_resp = 1'b1;
                dst_hresp       = 1'b0;
                dst_hrdata      = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin : monitor
        bit   in_dp;
        int   cyc;
        exp_t e;
        in_dp = 0; cyc = 0;
        forever begin
            @(negedge clk);
            if (in_dp) begin
                cyc++;
                if (src_hready_resp) begin
                    if (exp_q.size() == 0) begin
                        chk("exp_underflow", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dp_cycles", 64'(cyc), 64'(e.cycles));
                        chk("hresp", 64'(src_hresp), 64'(e.hresp));
                        chk("hexokay", 64'(src_hexokay), 64'(e.okay));
                        if (e.chk_rdata) chk("hrdata", 64'(src_hrdata), 64'(e.rdata));
                    end
                    in_dp = 0;
                end
            end
            if (!rst && src_hready && src_htrans[1]) begin
                in_dp = 1;
                cyc   = 0;
                chk("dst_htrans", 64'(dst_htrans), 64'(cur_supp ? 2'b00 : src_htrans));
                chk("passthru",
                    64'({dst_haddr, dst_hwrite, dst_hexcl, dst_hmaster, dst_hsize, dst_hburst,
                         dst_hprot, dst_hmastlock, dst_hready}),
                    64'({src_haddr, src_hwrite, src_hexcl, src_hmaster, src_hsize, src_hburst,
                         src_hprot, src_hmastlock, src_hready}));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : driver
        rst = 1'b1;
        src_haddr = 32'h0; src_hwrite = 1'b0; src_htrans = 2'b00; src_hsize = 3'd2;
        src_hburst = 3'd0; src_hprot = 4'h3; src_hmastlock = 1'b0; src_hwdata = 32'h0;
        src_hexcl = 1'b0; src_hmaster = 8'h0;
        pend_wdata = 32'h0; cur_supp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hexokay", 64'(src_hexokay), 64'd0);
        chk("rst_hready_resp", 64'(src_hready_resp), 64'd1);
        chk("rst_hresp", 64'(src_hresp), 64'd0);
        chk("rst_hrdata", 64'(src_hrdata), 64'h0000_0000_DEAD_BEEF);
        chk("rst_dst_htrans", 64'(dst_htrans), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First exclusive write after reset has no reservation
        xfer(0, 32'h1000, 1'b1, 1'b1, 0, 1'b0);
        // Read/write exclusive pair in one granule, then reservation is gone
        xfer(0, 32'h1000, 1'b0, 1'b1, 0, 1'b0);
        xfer(0, 32'h1004, 1'b1, 1'b1, 0, 1'b0);
        xfer(0, 32'h1004, 1'b1, 1'b1, 0, 1'b0);
        // Another master's plain write breaks the reservation; memory keeps that write
        xfer(0, 32'h1000, 1'b0, 1'b1, 0, 1'b0);
        xfer(1, 32'h1000, 1'b1, 1'b0, 0, 1'b0);
        xfer(0, 32'h1000, 1'b1, 1'b1, 0, 1'b0);
        xfer(0, 32'h1000, 1'b0, 1'b0, 0, 1'b0);
        // Two masters race on one granule; the winner kills the loser
        xfer(0, 32'h2000, 1'b0, 1'b1, 0, 1'b0);
        xfer(1, 32'h2000, 1'b0, 1'b1, 0, 1'b0);
        xfer(1, 32'h2000, 1'b1, 1'b1, 0, 1'b0);
        xfer(0, 32'h2000, 1'b1, 1'b1, 0, 1'b0);
        // Out-of-range master never holds a reservation
        xfer(5, 32'h1010, 1'b0, 1'b1, 0, 1'b0);
        xfer(5, 32'h1010, 1'b1, 1'b1, 0, 1'b0);
        // Erroring exclusive write still consumes the reservation
        xfer(0, 32'h3000, 1'b0, 1'b1, 0, 1'b0);
        xfer(0, 32'h3000, 1'b1, 1'b1, 3, 1'b1);
        xfer(0, 32'h3000, 1'b1, 1'b1, 0, 1'b0);
        // Reset during a data phase drops the reservation
        xfer(0, 32'h1000, 1'b0, 1'b1, 0, 1'b0);
        reset_pulse();
        xfer(0, 32'h1000, 1'b1, 1'b1, 0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int          m;
            logic [31:0] a;
            m = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       a = 32'h1000;
                1:       a = 32'h1004;
                2:       a = 32'h1008;
                3:       a = 32'h2000;
                default: a = 32'h2004;
            endcase
            xfer(m, a, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6),
                 int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
        end

        idle();
        repeat (20) @(posedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("sl_q_drained", 64'(sl_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
